// File: rtl/cdb_result_arbiter.sv
// Result-bus arbiter: buffers one completed result per execution pipe and
// broadcasts one per cycle in round-robin order on the common result bus.
// Latency 2 edges minimum (capture into slot, then win and register onto bus).
// Backpressure: per-pipe ready = slot empty or slot drained this cycle; the bus never stalls.
//
// Ports:
//   clk_in, reset_in            : clock (rising edge), async active-high reset
//   pipeN_valid/tag/data_in     : result offered by pipe N (N=1..4)
//   pipeN_ready_out             : pipe N holding slot can capture this cycle
//   cdb_valid/tag/data_out      : registered broadcast
//   cdb_grant_out               : one-hot source, bit3=pipe1 .. bit0=pipe4
//   cdb_src_sel_out             : encoded source, 0=pipe1 .. 3=pipe4
module cdb_result_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 6
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              pipe1_valid_in,
  input  logic [TAG_W-1:0]  pipe1_tag_in,
  input  logic [DATA_W-1:0] pipe1_data_in,
  output logic              pipe1_ready_out,
  input  logic              pipe2_valid_in,
  input  logic [TAG_W-1:0]  pipe2_tag_in,
  input  logic [DATA_W-1:0] pipe2_data_in,
  output logic              pipe2_ready_out,
  input  logic              pipe3_valid_in,
  input  logic [TAG_W-1:0]  pipe3_tag_in,
  input  logic [DATA_W-1:0] pipe3_data_in,
  output logic              pipe3_ready_out,
  input  logic              pipe4_valid_in,
  input  logic [TAG_W-1:0]  pipe4_tag_in,
  input  logic [DATA_W-1:0] pipe4_data_in,
  output logic              pipe4_ready_out,
  output logic              cdb_valid_out,
  output logic [TAG_W-1:0]  cdb_tag_out,
  output logic [DATA_W-1:0] cdb_data_out,
  output logic [3:0]        cdb_grant_out,
  output logic [1:0]        cdb_src_sel_out
);

  // Internally pipe N lives at index N-1.
  logic [3:0]        in_vld;
  logic [TAG_W-1:0]  in_tag [4];
  logic [DATA_W-1:0] in_dat [4];

  assign in_vld    = {pipe4_valid_in, pipe3_valid_in, pipe2_valid_in, pipe1_valid_in};
  assign in_tag[0] = pipe1_tag_in;
  assign in_tag[1] = pipe2_tag_in;
  assign in_tag[2] = pipe3_tag_in;
  assign in_tag[3] = pipe4_tag_in;
  assign in_dat[0] = pipe1_data_in;
  assign in_dat[1] = pipe2_data_in;
  assign in_dat[2] = pipe3_data_in;
  assign in_dat[3] = pipe4_data_in;

  logic [3:0]        slot_full;
  logic [TAG_W-1:0]  slot_tag [4];
  logic [DATA_W-1:0] slot_dat [4];
  logic [1:0]        rr_ptr;

  logic       gnt_any;
  logic [1:0] gnt_idx;
  logic [1:0] cand;
  logic [3:0] gnt_vec;
  logic [3:0] slot_rdy;
  logic [3:0] accept;

  // Scan from the pointer, wrapping; first full slot wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    cand    = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!gnt_any && slot_full[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt_vec  = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;
  // A slot being drained this cycle can take a new result on the same edge.
  assign slot_rdy = ~slot_full | gnt_vec;
  assign accept   = in_vld & slot_rdy;

  assign pipe1_ready_out = slot_rdy[0];
  assign pipe2_ready_out = slot_rdy[1];
  assign pipe3_ready_out = slot_rdy[2];
  assign pipe4_ready_out = slot_rdy[3];

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      slot_full <= 4'b0000;
      rr_ptr    <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        slot_tag[i] <= '0;
        slot_dat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept[i]) begin
          slot_full[i] <= 1'b1;
          slot_tag[i]  <= in_tag[i];
          slot_dat[i]  <= in_dat[i];
        end else if (gnt_vec[i]) begin
          slot_full[i] <= 1'b0;
        end
      end
      if (gnt_any) begin
        rr_ptr <= gnt_idx + 2'd1;
      end
    end
  end

  // Broadcast register; tag/data hold when idle since consumers qualify with valid.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      cdb_valid_out   <= 1'b0;
      cdb_tag_out     <= '0;
      cdb_data_out    <= '0;
      cdb_grant_out   <= 4'b0000;
      cdb_src_sel_out <= 2'b00;
    end else begin
      cdb_valid_out   <= gnt_any;
      cdb_grant_out   <= {gnt_vec[0], gnt_vec[1], gnt_vec[2], gnt_vec[3]};
      cdb_src_sel_out <= gnt_any ? gnt_idx : 2'b00;
      if (gnt_any) begin
        cdb_tag_out  <= slot_tag[gnt_idx];
        cdb_data_out <= slot_dat[gnt_idx];
      end
    end
  end

endmodule
